// File: rtl/spm_arbiter.sv
// Two-master arbiter for the single-port scratchpad: fixed m0 priority with a
// bounded-starvation override for m1, plus routing of 1-cycle read returns.
module spm_arbiter #(
  parameter int ADDR_W     = 12,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_rw,
  input  logic [DATA_W-1:0] m0_wr_data,
  output logic              m0_gnt,
  output logic [DATA_W-1:0] m0_rd_data,
  output logic              m0_rvalid,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_rw,
  input  logic [DATA_W-1:0] m1_wr_data,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m1_rd_data,
  output logic              m1_rvalid,
  output logic [ADDR_W-1:0] spm_addr,
  output logic              spm_as_,
  output logic              spm_rw,
  output logic [DATA_W-1:0] spm_wr_data,
  input  logic [DATA_W-1:0] spm_rd_data
);

  localparam logic       RW_READ    = 1'b1;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_cnt;
  logic       rd_pend;
  logic       rd_owner;
  logic       any_gnt;
  logic       rd_issue;

  always_comb begin
    m0_gnt = 1'b0;
    m1_gnt = 1'b0;
    if (rst_n) begin
      if (m0_req && m1_req) begin
        if (starve_cnt == STARVE_LIM) m1_gnt = 1'b1;
        else                          m0_gnt = 1'b1;
      end else begin
        m0_gnt = m0_req;
        m1_gnt = m1_req;
      end
    end
  end

  // Idle port keeps m0's address/data on the bus but never issues a write.
  always_comb begin
    any_gnt     = m0_gnt | m1_gnt;
    spm_as_     = ~any_gnt;
    spm_addr    = m1_gnt ? m1_addr    : m0_addr;
    spm_wr_data = m1_gnt ? m1_wr_data : m0_wr_data;
    if (m1_gnt)      spm_rw = m1_rw;
    else if (m0_gnt) spm_rw = m0_rw;
    else             spm_rw = RW_READ;
    rd_issue    = any_gnt && (spm_rw == RW_READ);
  end

  always_comb begin
    m0_rvalid  = rst_n && rd_pend && !rd_owner;
    m1_rvalid  = rst_n && rd_pend &&  rd_owner;
    m0_rd_data = m0_rvalid ? spm_rd_data : '0;
    m1_rd_data = m1_rvalid ? spm_rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      rd_pend    <= 1'b0;
      rd_owner   <= 1'b0;
    end else begin
      if (m1_gnt || !m1_req)
        starve_cnt <= '0;
      else if (m0_gnt && starve_cnt != STARVE_LIM)
        starve_cnt <= starve_cnt + 4'd1;
      rd_pend <= rd_issue;
      if (rd_issue) rd_owner <= m1_gnt;
    end
  end

endmodule

// File: tb/tb_spm_arbiter.sv
// Self-checking bench for spm_arbiter: behavioural spm model, shadow memory and
// per-master read-return scoreboard queues.
module tb_spm_arbiter;

  localparam int    ADDR_W = 12;
  localparam int    DATA_W = 32;
  localparam logic  RD     = 1'b1;
  localparam logic  WR     = 1'b0;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              m0_req, m0_rw, m1_req, m1_rw;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wr_data, m1_wr_data;
  logic              m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DATA_W-1:0] m0_rd_data, m1_rd_data;
  logic [ADDR_W-1:0] spm_addr;
  logic              spm_as_, spm_rw;
  logic [DATA_W-1:0] spm_wr_data, spm_rd_data;

  logic [DATA_W-1:0] mem [4096];
  logic [DATA_W-1:0] sh  [4096];
  logic [DATA_W-1:0] q0[$], q1[$];
  logic              due0, due1;
  int                n_cmp, n_err, n_rv0, n_rv1;
  logic [DATA_W-1:0] exp_d;

  always #5 clk = ~clk;

  spm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_rw(m0_rw), .m0_wr_data(m0_wr_data),
    .m0_gnt(m0_gnt), .m0_rd_data(m0_rd_data), .m0_rvalid(m0_rvalid),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_rw(m1_rw), .m1_wr_data(m1_wr_data),
    .m1_gnt(m1_gnt), .m1_rd_data(m1_rd_data), .m1_rvalid(m1_rvalid),
    .spm_addr(spm_addr), .spm_as_(spm_as_), .spm_rw(spm_rw),
    .spm_wr_data(spm_wr_data), .spm_rd_data(spm_rd_data)
  );

  // Scratchpad model: synchronous write, 1-cycle read latency.
  always @(posedge clk) begin
    if (!spm_as_) begin
      if (spm_rw == RD) spm_rd_data <= mem[spm_addr];
      else              mem[spm_addr] <= spm_wr_data;
    end
  end

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Return-path scoreboard: reads granted this cycle are due next cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_gnt", {m0_gnt, m1_gnt}, 0);
      chk("rst_as", spm_as_, 1);
      chk("rst_rvalid", {m0_rvalid, m1_rvalid}, 0);
      chk("rst_rd_data", m0_rd_data | m1_rd_data, 0);
      q0.delete();
      q1.delete();
      due0 = 1'b0;
      due1 = 1'b0;
    end else begin
      chk("m0_rvalid", m0_rvalid, due0);
      chk("m1_rvalid", m1_rvalid, due1);
      if (due0) begin
        exp_d = q0.pop_front();
        if (m0_rvalid) chk("m0_rd_data", m0_rd_data, exp_d);
      end else chk("m0_rd_idle", m0_rd_data, 0);
      if (due1) begin
        exp_d = q1.pop_front();
        if (m1_rvalid) chk("m1_rd_data", m1_rd_data, exp_d);
      end else chk("m1_rd_idle", m1_rd_data, 0);
      if (m0_rvalid) n_rv0++;
      if (m1_rvalid) n_rv1++;
      chk("gnt_excl", m0_gnt & m1_gnt, 0);
      chk("spm_as", spm_as_, !(m0_gnt || m1_gnt));
      if (m0_gnt) chk("spm_addr_m0", spm_addr, m0_addr);
      if (m1_gnt) chk("spm_addr_m1", spm_addr, m1_addr);
      if (!m0_gnt && !m1_gnt) chk("idle_rw", spm_rw, RD);
      due0 = m0_gnt && m0_rw == RD;
      due1 = m1_gnt && m1_rw == RD;
      if (due0) q0.push_back(sh[m0_addr]);
      if (due1) q1.push_back(sh[m1_addr]);
      if (m0_gnt && m0_rw == WR) sh[m0_addr] = m0_wr_data;
      if (m1_gnt && m1_rw == WR) sh[m1_addr] = m1_wr_data;
    end
  end

  task automatic drive(input int m, input logic req, input logic rw,
                       input int addr, input logic [DATA_W-1:0] d);
    if (m == 0) begin
      m0_req = req; m0_rw = rw; m0_addr = ADDR_W'(addr); m0_wr_data = d;
    end else begin
      m1_req = req; m1_rw = rw; m1_addr = ADDR_W'(addr); m1_wr_data = d;
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      mem[i] = '0;
      sh[i]  = '0;
    end
    n_cmp = 0; n_err = 0; n_rv0 = 0; n_rv1 = 0;
    due0 = 1'b0; due1 = 1'b0;
    spm_rd_data = '0;
    rst_n = 1'b0;
    drive(0, 1, RD, 100, 0);
    drive(1, 1, RD, 101, 0);

    // 1: reset held 3 cycles with both requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t1_no_gnt", {m0_gnt, m1_gnt}, 0);
    end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t1_first_gnt", {m0_gnt, m1_gnt}, 2'b10);
    step();
    drive(0, 0, RD, 0, 0);
    drive(1, 0, RD, 0, 0);

    // 2: m0 writes then back-to-back reads
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, WR, i, DATA_W'(255 - i));
      @(negedge clk);
      chk("t2_wr_gnt", m0_gnt, 1);
      step();
    end
    n_rv0 = 0;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, RD, i, 0);
      @(negedge clk);
      chk("t2_rd_gnt", m0_gnt, 1);
      step();
    end
    drive(0, 0, RD, 0, 0);
    step();
    chk("t2_rv_count", n_rv0, 16);

    // 3: continuous contention, STARVE_MAX=4
    drive(0, 1, RD, 3, 0);
    drive(1, 1, RD, 5, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t3_pattern", {m0_gnt, m1_gnt}, (i % 5 == 4) ? 2'b01 : 2'b10);
      step();
    end
    drive(0, 0, RD, 0, 0);
    drive(1, 0, RD, 0, 0);
    step();

    // 4: alternating grants, m0 addr 3 then m1 addr 5
    n_rv0 = 0; n_rv1 = 0;
    drive(0, 1, RD, 3, 0);
    @(negedge clk);
    chk("t4_m0_gnt", m0_gnt, 1);
    step();
    drive(0, 0, RD, 0, 0);
    drive(1, 1, RD, 5, 0);
    @(negedge clk);
    chk("t4_m1_gnt", m1_gnt, 1);
    chk("t4_m0_data", m0_rd_data, 252);
    step();
    drive(1, 0, RD, 0, 0);
    @(negedge clk);
    chk("t4_m1_data", m1_rd_data, 250);
    step();
    chk("t4_counts", {n_rv0[7:0], n_rv1[7:0]}, 16'h0101);

    // 5: m1 alone writes then reads addr 7
    drive(1, 1, WR, 7, 32'hA5);
    @(negedge clk);
    chk("t5_wr_gnt", {m0_gnt, m1_gnt}, 2'b01);
    step();
    drive(1, 1, RD, 7, 0);
    @(negedge clk);
    chk("t5_rd_gnt", {m0_gnt, m1_gnt}, 2'b01);
    step();
    drive(1, 0, RD, 0, 0);
    @(negedge clk);
    chk("t5_m1_data", m1_rd_data, 32'hA5);
    chk("t5_m0_idle", m0_rvalid, 0);
    step();

    // 6a: reset in the cycle after an m1 read grant drops the return
    n_rv1 = 0;
    drive(1, 1, RD, 7, 0);
    @(negedge clk);
    chk("t6_m1_gnt", m1_gnt, 1);
    step();
    drive(1, 0, RD, 0, 0);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    step();
    chk("t6_no_rvalid", n_rv1, 0);
    // 6b: saturated starvation count is cleared by reset
    drive(0, 1, RD, 1, 0);
    drive(1, 1, RD, 2, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t6_m0_run", m0_gnt, 1);
      step();
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_after_rst", {m0_gnt, m1_gnt}, 2'b10);
    step();
    drive(0, 0, RD, 0, 0);
    drive(1, 0, RD, 0, 0);
    step();
    step();
    chk("sb_empty", q0.size() + q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
